rx_iq_scheduler: RTL and testbench
==================================

# rx_iq_scheduler

Buffers decimated RX1/RX2 IQ samples from the DDC chain and sequences them byte by byte onto the STM32 parallel-bus transmit path. It sits between the receive CIC/FIR outputs and the STM32 bus interface, and replaces direct sampling of live IQ registers during an RX IQ burst (command 4). It decouples the DDC output rate from the bus read rate with a 4-entry sample FIFO. It reports overrun and underrun to the parameter readback.

## Interface
Parameters:
- FIFO_DEPTH, 4, sample entries (power of two, 2..16)
- IQ_WIDTH, 24, bits per I or Q component

Ports:
- clk_in  in  1  bus/system clock; all logic on rising edge
- rst_in  in  1  asynchronous, active-high reset
- rx1_i, rx1_q, rx2_i, rx2_q  in  IQ_WIDTH each  signed DDC outputs
- iq_valid  in  1  one-cycle strobe: new sample set present on the rx* inputs
- rx2_enable  in  1  include the RX2 pair in each sample frame
- start  in  1  one-cycle pulse; begin an IQ burst (command 4 decoded)
- stop  in  1  one-cycle pulse; end the burst (new DATA_SYNC command)
- byte_req  in  1  one-cycle pulse; bus has consumed the current byte
- flag_clr  in  1  clear sticky flags
- byte_out  out  8  current byte to drive on DATA_BUS
- active  out  1  burst in progress
- iq_overrun  out  1  sticky: sample dropped because the FIFO was full
- iq_underrun  out  1  sticky: frame reloaded while the FIFO was empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries

## Operation
- FIFO entry: {rx1_q, rx1_i, rx2_q, rx2_i}, 96 bits.
- iq_valid pushes one entry when the FIFO is not full.
- iq_valid while full and no pop in the same cycle: drop the sample, set iq_overrun.
- iq_valid while full with a pop in the same cycle: push is accepted.
- States:
  - IDLE: byte_out = 0, active = 0. start moves to ACTIVE.
  - ACTIVE: serves bytes. stop moves to IDLE.
- Frame load (on start, and on byte_req at the last byte of a frame):
  - idx := 0.
  - Latch rx2_enable into frame_rx2.
  - If the FIFO is not empty, pop the head into the shadow register.
  - If the FIFO is empty, keep the shadow unchanged (repeat the previous sample) and set iq_underrun.
  - No push-to-pop bypass: an empty FIFO at a load is an underrun even if iq_valid arrives in the same cycle.
- Byte order, MSB first within each component:
  - idx 0-2: rx1_q
  - idx 3-5: rx1_i
  - idx 6-8: rx2_q (only when frame_rx2 = 1)
  - idx 9-11: rx2_i (only when frame_rx2 = 1)
- Last byte: idx 5 when frame_rx2 = 0, idx 11 when frame_rx2 = 1.
- byte_req, not at the last byte: idx += 1.
- byte_out is a mux of the shadow register by idx.
- rx2_enable changes mid-frame have no effect until the next frame load.
- start while ACTIVE: restart. Perform a frame load; bytes of the partially sent frame are discarded.
- stop and start in the same cycle: start wins.
- stop does not flush the FIFO; the shadow register is retained.
- flag_clr and a flag-setting event in the same cycle: the flag ends set.
- Reset values: state IDLE, FIFO empty, idx 0, shadow 0, byte_out 0, active 0, iq_overrun 0, iq_underrun 0, fifo_level 0, frame_rx2 0.

## Timing
- Push/pop: a push is visible in fifo_level the cycle after the iq_valid edge; the same holds for a pop.
- byte_out latency: valid one clk_in cycle after the edge that sampled start or byte_req. The bus interface drives it on its next state step.
- Pulse spacing: byte_req pulses are at least 1 cycle apart; back-to-back pulses are legal.
- Burst throughput: one byte per cycle sustained.
- Reset mid-burst: asynchronous return to the reset values, with no glitch on active after deassertion.

## Structure
- Shared package `rx_iq_pkg` holds:
  - IQ_WIDTH
  - the entry-field offsets
  - byte index constants LAST_IDX_RX1 = 5 and LAST_IDX_RX2 = 11
  - the state enum {IDLE, ACTIVE}
- One sub-module, `iq_sample_fifo`: synchronous single-clock FIFO with push, pop, full, empty and level outputs.
- Sequencing, shadow register and flags live in `rx_iq_scheduler`.

## Test plan
- Reset, then push one sample with rx1_q=0x123456, rx1_i=0xABCDEF and rx2_enable=0; pulse start, then 5 byte_req → byte_out sequence 12 34 56 AB CD EF; fifo_level 1→0.
- rx2_enable=1, push one sample with rx2_q=0x010203, rx2_i=0xFFFF80; start, then 11 byte_req → 12 bytes with the last six being 01 02 03 FF FF 80. Toggling rx2_enable at idx 3 does not change the frame length.
- 5 iq_valid with no reads (FIFO_DEPTH=4) → fifo_level=4, iq_overrun=1 after the 5th; the 5th sample is never output. flag_clr → iq_overrun=0.
- Full FIFO with iq_valid coinciding with the frame-load pop → no overrun, level stays 4.
- Empty FIFO; start → byte_out repeats the previous shadow sample and iq_underrun=1. With a push in the same cycle as the load, underrun is still set and level becomes 1.
- Assert rst_in at idx 7 → active=0, byte_out=0, level=0 immediately. Then a mid-frame start → idx restarts at 0 with the next FIFO sample.

Source files
------------

// File: rtl/rx_iq_scheduler_pkg.sv
// rx_iq_scheduler shared definitions.
// Entry layout, byte indices and FSM states.
package rx_iq_pkg;

  localparam int IQ_WIDTH  = 24;
  localparam int ENTRY_W   = 4 * IQ_WIDTH;

  localparam int RX2_I_OFF = 0;
  localparam int RX2_Q_OFF = IQ_WIDTH;
  localparam int RX1_I_OFF = 2 * IQ_WIDTH;
  localparam int RX1_Q_OFF = 3 * IQ_WIDTH;

  localparam logic [3:0] LAST_IDX_RX1 = 4'd5;
  localparam logic [3:0] LAST_IDX_RX2 = 4'd11;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

endpackage

// File: rtl/rx_iq_scheduler_if.sv
// rx_iq_scheduler sample/control/bus bundle.
// master drives samples and commands, slave is the scheduler.
interface rx_iq_scheduler_if #(
  parameter int IQ_WIDTH   = 24,
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic signed [IQ_WIDTH-1:0] rx1_i;
  logic signed [IQ_WIDTH-1:0] rx1_q;
  logic signed [IQ_WIDTH-1:0] rx2_i;
  logic signed [IQ_WIDTH-1:0] rx2_q;
  logic          iq_valid;
  logic          rx2_enable;
  logic          start;
  logic          stop;
  logic          byte_req;
  logic          flag_clr;
  logic [7:0]    byte_out;
  logic          active;
  logic          iq_overrun;
  logic          iq_underrun;
  logic [LW-1:0] fifo_level;

  modport master (
    output rx1_i, rx1_q, rx2_i, rx2_q,
    output iq_valid, rx2_enable, start, stop,
    output byte_req, flag_clr,
    input  byte_out, active, iq_overrun,
    input  iq_underrun, fifo_level
  );

  modport slave (
    input  rx1_i, rx1_q, rx2_i, rx2_q,
    input  iq_valid, rx2_enable, start, stop,
    input  byte_req, flag_clr,
    output byte_out, active, iq_overrun,
    output iq_underrun, fifo_level
  );

endinterface

// File: rtl/rx_iq_scheduler_fifo.sv
// iq_sample_fifo: single-clock sample FIFO.
// A push into a full FIFO is taken only when a pop frees a slot.
module iq_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 96,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign head_o  = mem[rd_q];
  assign level_o = level_q;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // next pointers and occupancy
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    level_d = level_q;
    if (do_pop)  rd_d = rd_q + AW'(1);
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_push && !do_pop) level_d = level_q + LW'(1);
    if (!do_push && do_pop) level_d = level_q - LW'(1);
  end

  // pointer and level registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      level_q <= level_d;
    end
  end

  // storage write
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_q] <= din_i;
  end

endmodule

// File: rtl/rx_iq_scheduler.sv
// rx_iq_scheduler: buffers DDC IQ frames and serves
// them byte by byte to the STM32 parallel bus.
module rx_iq_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int IQ_WIDTH   = rx_iq_pkg::IQ_WIDTH
) (
  input logic          clk_in,
  input logic          rst_in,
  rx_iq_scheduler_if.slave bus
);
  import rx_iq_pkg::*;

  localparam int EW = 4 * IQ_WIDTH;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [EW-1:0] shadow_q, shadow_d;
  logic [EW-1:0] entry, head, sh;
  logic          frx2_q, frx2_d;
  logic          ovr_q, ovr_d;
  logic          und_q, und_d;
  logic          load, pop, last;
  logic          full, empty;
  logic [LW-1:0] level;

  // pack the live sample set into one FIFO entry
  always_comb begin
    entry = '0;
    entry[RX1_Q_OFF +: IQ_WIDTH] = bus.rx1_q;
    entry[RX1_I_OFF +: IQ_WIDTH] = bus.rx1_i;
    entry[RX2_Q_OFF +: IQ_WIDTH] = bus.rx2_q;
    entry[RX2_I_OFF +: IQ_WIDTH] = bus.rx2_i;
  end

  iq_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .push_i  (bus.iq_valid),
    .pop_i   (pop),
    .din_i   (entry),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign last = frx2_q ? (idx_q == LAST_IDX_RX2)
                       : (idx_q == LAST_IDX_RX1);

  // sequencing, frame load and sticky flags
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    frx2_d   = frx2_q;
    ovr_d    = ovr_q;
    und_d    = und_q;
    load     = 1'b0;
    pop      = 1'b0;
    if (bus.flag_clr) begin
      ovr_d = 1'b0;
      und_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (bus.start) begin
          load = 1'b1;
        end else if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.byte_req) begin
          if (last) load = 1'b1;
          else      idx_d = idx_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      idx_d  = '0;
      frx2_d = bus.rx2_enable;
      if (!empty) begin
        pop      = 1'b1;
        shadow_d = head;
      end else begin
        und_d = 1'b1;
      end
    end
    if (bus.iq_valid && full && !pop) ovr_d = 1'b1;
  end

  // state, shadow and flag registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      frx2_q   <= 1'b0;
      ovr_q    <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      frx2_q   <= frx2_d;
      ovr_q    <= ovr_d;
      und_q    <= und_d;
    end
  end

  assign sh = shadow_q << {idx_q, 3'b000};

  assign bus.byte_out    = (state_q == ACTIVE) ? sh[EW-1 -: 8] : 8'h00;
  assign bus.active      = (state_q == ACTIVE);
  assign bus.iq_overrun  = ovr_q;
  assign bus.iq_underrun = und_q;
  assign bus.fifo_level  = level;

endmodule

// File: tb/tb_rx_iq_scheduler.sv
// rx_iq_scheduler bench: directed scenarios plus random
// traffic against a queue-based frame model.
`timescale 1ns/1ps
module tb_rx_iq_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rx_iq_scheduler_if #(.IQ_WIDTH(24), .FIFO_DEPTH(4)) ifc ();

  rx_iq_scheduler #(
    .FIFO_DEPTH (4),
    .IQ_WIDTH   (24)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (ifc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [95:0] mq[$];
  logic [95:0] m_sh;
  int          m_idx;
  bit          m_frx2, m_act, m_ovr, m_und;

  function automatic void m_reset();
    mq.delete();
    m_sh = '0; m_idx = 0; m_frx2 = 0;
    m_act = 0; m_ovr = 0; m_und = 0;
  endfunction

  function automatic void m_step();
    int lastb;
    bit was_full, ld, popped, adv;
    lastb    = m_frx2 ? 11 : 5;
    was_full = (mq.size() == 4);
    adv      = m_act && ifc.byte_req && !ifc.stop;
    ld       = ifc.start || (adv && m_idx == lastb);
    popped   = 0;
    if (ifc.flag_clr) begin m_ovr = 0; m_und = 0; end
    if (ld) begin
      m_idx  = 0;
      m_frx2 = ifc.rx2_enable;
      if (mq.size() == 0) m_und = 1;
      else begin m_sh = mq.pop_front(); popped = 1; end
    end else if (adv) begin
      m_idx++;
    end
    if (ifc.start) m_act = 1;
    else if (ifc.stop) m_act = 0;
    if (ifc.iq_valid) begin
      if (!was_full || popped)
        mq.push_back({ifc.rx1_q, ifc.rx1_i, ifc.rx2_q, ifc.rx2_i});
      else
        m_ovr = 1;
    end
  endfunction

  function automatic logic [7:0] m_byte();
    logic [23:0] comp[4];
    int c, b;
    if (!m_act) return 8'h00;
    comp[0] = m_sh[95:72];
    comp[1] = m_sh[71:48];
    comp[2] = m_sh[47:24];
    comp[3] = m_sh[23:0];
    c = m_idx / 3;
    b = m_idx % 3;
    return 8'(comp[c] >> (16 - 8 * b));
  endfunction

  task automatic clear_pulses();
    ifc.start = 0; ifc.stop = 0; ifc.byte_req = 0;
    ifc.iq_valid = 0; ifc.flag_clr = 0;
  endtask

  task automatic set_sample(input logic [95:0] s);
    {ifc.rx1_q, ifc.rx1_i, ifc.rx2_q, ifc.rx2_i} = s;
  endtask

  function automatic logic [95:0] rnd96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) m_reset();
    else m_step();
    #1;
    clear_pulses();
  endtask

  task automatic test_reset();
    clear_pulses();
    ifc.rx2_enable = 0;
    set_sample('0);
    rst = 1;
    repeat (3) tick();
    @(negedge clk);
    rst = 0;
    n_tests++;
    if (ifc.byte_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_byte got %h want 00", ifc.byte_out);
    end
    n_tests++;
    if (ifc.active !== 1'b0) begin
      n_fail++; $display("FAIL reset_active got %b want 0", ifc.active);
    end
    n_tests++;
    if (ifc.fifo_level !== 3'd0) begin
      n_fail++; $display("FAIL reset_level got %0d want 0", ifc.fifo_level);
    end
    n_tests++;
    if (ifc.iq_overrun !== 1'b0 || ifc.iq_underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got ovr=%b und=%b want 0 0",
               ifc.iq_overrun, ifc.iq_underrun);
    end
  endtask

  task automatic test_rx1_frame();
    logic [7:0] exp[6];
    exp = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
    ifc.rx2_enable = 0;
    set_sample({24'h123456, 24'hABCDEF, 48'(rnd96())});
    ifc.iq_valid = 1;
    tick();
    n_tests++;
    if (ifc.fifo_level !== 3'd1) begin
      n_fail++; $display("FAIL rx1_push_level got %0d want 1", ifc.fifo_level);
    end
    ifc.start = 1;
    tick();
    n_tests++;
    if (ifc.fifo_level !== 3'd0 || ifc.active !== 1'b1) begin
      n_fail++;
      $display("FAIL rx1_start got level=%0d act=%b want 0 1",
               ifc.fifo_level, ifc.active);
    end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin ifc.byte_req = 1; tick(); end
      n_tests++;
      if (ifc.byte_out !== exp[i]) begin
        n_fail++;
        $display("FAIL rx1_byte%0d got %h want %h", i, ifc.byte_out, exp[i]);
      end
    end
    ifc.stop = 1;
    tick();
    n_tests++;
    if (ifc.active !== 1'b0 || ifc.byte_out !== 8'h00) begin
      n_fail++;
      $display("FAIL rx1_stop got act=%b byte=%h want 0 00",
               ifc.active, ifc.byte_out);
    end
  endtask

  task automatic test_rx2_frame();
    logic [7:0] exp[12];
    exp = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF,
            8'h01, 8'h02, 8'h03, 8'hFF, 8'hFF, 8'h80};
    ifc.rx2_enable = 1;
    set_sample({24'h123456, 24'hABCDEF, 24'h010203, 24'hFFFF80});
    ifc.iq_valid = 1;
    tick();
    ifc.start = 1;
    tick();
    for (int i = 0; i < 12; i++) begin
      if (i == 3) ifc.rx2_enable = 0;
      if (i > 0) begin ifc.byte_req = 1; tick(); end
      n_tests++;
      if (ifc.byte_out !== exp[i]) begin
        n_fail++;
        $display("FAIL rx2_byte%0d got %h want %h", i, ifc.byte_out, exp[i]);
      end
    end
    ifc.byte_req = 1;
    tick();
    n_tests++;
    if (ifc.byte_out !== 8'h12 || ifc.iq_underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL rx2_wrap got byte=%h und=%b want 12 1",
               ifc.byte_out, ifc.iq_underrun);
    end
    ifc.flag_clr = 1;
    ifc.stop = 1;
    tick();
    n_tests++;
    if (ifc.iq_underrun !== 1'b0) begin
      n_fail++; $display("FAIL rx2_clr got und=%b want 0", ifc.iq_underrun);
    end
  endtask

  task automatic test_overrun();
    logic [95:0] s[5];
    for (int i = 0; i < 5; i++) begin
      s[i] = rnd96();
      set_sample(s[i]);
      ifc.iq_valid = 1;
      tick();
      n_tests++;
      if (ifc.fifo_level !== 3'((i < 4) ? i + 1 : 4)) begin
        n_fail++;
        $display("FAIL ovr_level%0d got %0d", i, ifc.fifo_level);
      end
      n_tests++;
      if (ifc.iq_overrun !== (i == 4)) begin
        n_fail++;
        $display("FAIL ovr_flag%0d got %b want %b", i, ifc.iq_overrun, i == 4);
      end
    end
    ifc.flag_clr = 1;
    tick();
    n_tests++;
    if (ifc.iq_overrun !== 1'b0) begin
      n_fail++; $display("FAIL ovr_clr got %b want 0", ifc.iq_overrun);
    end
    for (int i = 0; i < 4; i++) begin
      ifc.start = 1;
      tick();
      n_tests++;
      if (ifc.byte_out !== s[i][95:88]) begin
        n_fail++;
        $display("FAIL ovr_drain%0d got %h want %h",
                 i, ifc.byte_out, s[i][95:88]);
      end
    end
    n_tests++;
    if (ifc.fifo_level !== 3'd0) begin
      n_fail++; $display("FAIL ovr_empty got %0d want 0", ifc.fifo_level);
    end
  endtask

  task automatic test_full_pop();
    logic [95:0] first;
    for (int i = 0; i < 4; i++) begin
      set_sample(rnd96());
      if (i == 0) first = {ifc.rx1_q, ifc.rx1_i, ifc.rx2_q, ifc.rx2_i};
      ifc.iq_valid = 1;
      tick();
    end
    set_sample(rnd96());
    ifc.iq_valid = 1;
    ifc.start = 1;
    tick();
    n_tests++;
    if (ifc.fifo_level !== 3'd4 || ifc.iq_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL fullpop got level=%0d ovr=%b want 4 0",
               ifc.fifo_level, ifc.iq_overrun);
    end
    n_tests++;
    if (ifc.byte_out !== first[95:88]) begin
      n_fail++;
      $display("FAIL fullpop_byte got %h want %h", ifc.byte_out, first[95:88]);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] prev;
    repeat (4) begin ifc.start = 1; tick(); end
    prev = m_byte();
    ifc.start = 1;
    tick();
    n_tests++;
    if (ifc.iq_underrun !== 1'b1 || ifc.byte_out !== prev) begin
      n_fail++;
      $display("FAIL und_repeat got und=%b byte=%h want 1 %h",
               ifc.iq_underrun, ifc.byte_out, prev);
    end
    ifc.flag_clr = 1;
    tick();
    set_sample(rnd96());
    ifc.flag_clr = 1;
    ifc.iq_valid = 1;
    ifc.start = 1;
    tick();
    n_tests++;
    if (ifc.iq_underrun !== 1'b1 || ifc.fifo_level !== 3'd1) begin
      n_fail++;
      $display("FAIL und_push got und=%b level=%0d want 1 1",
               ifc.iq_underrun, ifc.fifo_level);
    end
  endtask

  task automatic test_reset_mid();
    logic [95:0] b, c;
    ifc.rx2_enable = 1;
    ifc.start = 1;
    tick();
    repeat (7) begin ifc.byte_req = 1; tick(); end
    n_tests++;
    if (ifc.byte_out !== m_byte()) begin
      n_fail++;
      $display("FAIL mid_idx7 got %h want %h", ifc.byte_out, m_byte());
    end
    #2 rst = 1;
    #1;
    m_reset();
    n_tests++;
    if (ifc.active !== 1'b0 || ifc.byte_out !== 8'h00 ||
        ifc.fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_rst got act=%b byte=%h level=%0d want 0 00 0",
               ifc.active, ifc.byte_out, ifc.fifo_level);
    end
    tick();
    @(negedge clk);
    rst = 0;
    b = rnd96();
    c = rnd96();
    set_sample(b); ifc.iq_valid = 1; tick();
    set_sample(c); ifc.iq_valid = 1; tick();
    ifc.start = 1;
    tick();
    repeat (3) begin ifc.byte_req = 1; tick(); end
    ifc.start = 1;
    tick();
    n_tests++;
    if (ifc.byte_out !== c[95:88]) begin
      n_fail++;
      $display("FAIL mid_restart got %h want %h", ifc.byte_out, c[95:88]);
    end
    ifc.byte_req = 1;
    tick();
    n_tests++;
    if (ifc.byte_out !== c[87:80]) begin
      n_fail++;
      $display("FAIL mid_next got %h want %h", ifc.byte_out, c[87:80]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      set_sample(rnd96());
      ifc.iq_valid = ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 99) < 10) ifc.rx2_enable = ~ifc.rx2_enable;
      ifc.start    = ($urandom_range(0, 99) < 3);
      ifc.stop     = ($urandom_range(0, 99) < 3);
      ifc.byte_req = ($urandom_range(0, 99) < 60);
      ifc.flag_clr = ($urandom_range(0, 99) < 5);
      tick();
      n_tests++;
      if (ifc.byte_out !== m_byte()) begin
        n_fail++;
        $display("FAIL rnd_byte c%0d got %h want %h", i, ifc.byte_out, m_byte());
      end
      n_tests++;
      if (ifc.active !== m_act) begin
        n_fail++;
        $display("FAIL rnd_active c%0d got %b want %b", i, ifc.active, m_act);
      end
      n_tests++;
      if (ifc.fifo_level !== 3'(mq.size())) begin
        n_fail++;
        $display("FAIL rnd_level c%0d got %0d want %0d",
                 i, ifc.fifo_level, mq.size());
      end
      n_tests++;
      if (ifc.iq_overrun !== m_ovr || ifc.iq_underrun !== m_und) begin
        n_fail++;
        $display("FAIL rnd_flags c%0d got %b%b want %b%b", i,
                 ifc.iq_overrun, ifc.iq_underrun, m_ovr, m_und);
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_rx1_frame();
    test_rx2_frame();
    test_overrun();
    test_full_pop();
    test_underrun();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
